// File: rtl/icache_refill_assembler_if.sv
// AXI read address/data channel bundle between the refill assembler
// (master) and the memory side (slave).
interface icache_refill_assembler_if #(
    parameter int unsigned BeatWidth = 64,
    parameter int unsigned PlenWidth = 56,
    parameter int unsigned IdWidth   = 4
);
    logic                 ar_valid_o;
    logic                 ar_ready_i;
    logic [PlenWidth-1:0] ar_addr_o;
    logic [7:0]           ar_len_o;
    logic [2:0]           ar_size_o;
    logic [1:0]           ar_burst_o;
    logic [IdWidth-1:0]   ar_id_o;
    logic                 r_valid_i;
    logic                 r_ready_o;
    logic [BeatWidth-1:0] r_data_i;
    logic                 r_last_i;
    logic [1:0]           r_resp_i;

    modport master (
        output ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o,
        output ar_id_o, r_ready_o,
        input  ar_ready_i, r_valid_i, r_data_i, r_last_i, r_resp_i
    );

    modport slave (
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o,
        input  ar_id_o, r_ready_o,
        output ar_ready_i, r_valid_i, r_data_i, r_last_i, r_resp_i
    );
endinterface

// File: rtl/icache_refill_assembler.sv
// Icache refill: one AR burst per miss, R beats assembled into a line.
// Define ICACHE_REFILL_CWF_EN for critical-word-first WRAP bursts.
module icache_refill_assembler #(
    parameter int unsigned LineWidth = 128,
    parameter int unsigned BeatWidth = 64,
    parameter int unsigned PlenWidth = 56,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned TidWidth  = 2,
    parameter int unsigned AxiId     = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [PlenWidth-1:0] req_paddr_i,
    input  logic                 req_nc_i,
    input  logic [TidWidth-1:0]  req_tid_i,
    icache_refill_assembler_if.master axi,
    output logic                 rtrn_valid_o,
    output logic [LineWidth-1:0] rtrn_data_o,
    output logic [TidWidth-1:0]  rtrn_tid_o,
    output logic                 rtrn_err_o,
    output logic                 busy_o
);
    localparam int unsigned NumBeats = LineWidth / BeatWidth;
    localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int unsigned LineOff  = $clog2(LineWidth / 8);
    localparam int unsigned BeatOff  = $clog2(BeatWidth / 8);
    localparam logic [1:0]  BurstIncr = 2'b01;
    localparam logic [1:0]  BurstWrap = 2'b10;
    localparam logic [CntW-1:0] CntMax = CntW'(NumBeats - 1);

    typedef enum logic [1:0] {IDLE, AR, DATA, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [PlenWidth-1:0]  paddr_q, paddr_d;
    logic                  nc_q, nc_d;
    logic [TidWidth-1:0]   tid_q, tid_d;
    logic                  flush_q, flush_d;
    logic [LineWidth-1:0]  line_q, line_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rtrn_q, rtrn_d;

    logic                  ar_active;
    logic [CntW-1:0]       cnt_start;
    logic [CntW-1:0]       cnt_next;
    logic [CntW-1:0]       slot;
    logic [PlenWidth-1:0]  line_addr;
    logic [PlenWidth-1:0]  beat_addr;
    logic                  unused_resp;

    assign unused_resp = axi.r_resp_i[0];
    assign line_addr   = {paddr_q[PlenWidth-1:LineOff], {LineOff{1'b0}}};
    assign beat_addr   = {paddr_q[PlenWidth-1:BeatOff], {BeatOff{1'b0}}};
    assign slot        = nc_q ? '0 : cnt_q;

`ifdef ICACHE_REFILL_CWF_EN
    // Start at the missed word and let the counter wrap with the burst.
    assign cnt_start = req_nc_i ? '0 : CntW'(req_paddr_i >> BeatOff);
    assign cnt_next  = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
`else
    assign cnt_start = '0;
    assign cnt_next  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        nc_d        = nc_q;
        tid_d       = tid_q;
        flush_d     = flush_q;
        line_d      = line_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rtrn_d      = 1'b0;
        req_ready_o = 1'b0;
        ar_active   = 1'b0;
        axi.r_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    paddr_d = req_paddr_i;
                    nc_d    = req_nc_i;
                    tid_d   = req_tid_i;
                    flush_d = 1'b0;
                    line_d  = '0;
                    err_d   = 1'b0;
                    cnt_d   = cnt_start;
                    state_d = AR;
                end
            end
            AR: begin
                ar_active = 1'b1;
                flush_d   = flush_q | flush_i;
                if (axi.ar_ready_i) begin
                    state_d = (flush_q | flush_i) ? DRAIN : DATA;
                end
            end
            DATA: begin
                axi.r_ready_o = 1'b1;
                if (flush_i) begin
                    // A last beat taken with the flush already ends the burst.
                    state_d = (axi.r_valid_i && axi.r_last_i) ? IDLE : DRAIN;
                end else if (axi.r_valid_i) begin
                    line_d[slot*BeatWidth +: BeatWidth] = axi.r_data_i;
                    err_d = err_q | axi.r_resp_i[1];
                    cnt_d = cnt_next;
                    if (axi.r_last_i) begin
                        rtrn_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                axi.r_ready_o = 1'b1;
                if (axi.r_valid_i && axi.r_last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            paddr_q <= '0;
            nc_q    <= 1'b0;
            tid_q   <= '0;
            flush_q <= 1'b0;
            line_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rtrn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            paddr_q <= paddr_d;
            nc_q    <= nc_d;
            tid_q   <= tid_d;
            flush_q <= flush_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rtrn_q  <= rtrn_d;
        end
    end

    assign axi.ar_valid_o = ar_active;
    assign axi.ar_size_o  = ar_active ? 3'(BeatOff) : 3'd0;
    assign axi.ar_id_o    = ar_active ? IdWidth'(AxiId) : '0;
    assign axi.ar_len_o   = (ar_active && !nc_q) ? 8'(NumBeats - 1) : 8'd0;

`ifdef ICACHE_REFILL_CWF_EN
    assign axi.ar_addr_o  = !ar_active ? '0 : (nc_q ? beat_addr : beat_addr);
    assign axi.ar_burst_o = !ar_active ? 2'b00 : (nc_q ? BurstIncr : BurstWrap);
`else
    assign axi.ar_addr_o  = !ar_active ? '0 : (nc_q ? beat_addr : line_addr);
    assign axi.ar_burst_o = ar_active ? BurstIncr : 2'b00;
`endif

    assign rtrn_valid_o = rtrn_q;
    assign rtrn_data_o  = rtrn_q ? line_q : '0;
    assign rtrn_tid_o   = rtrn_q ? tid_q : '0;
    assign rtrn_err_o   = rtrn_q & err_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_icache_refill_assembler.sv
// Directed bench for icache_refill_assembler: fills, nc, flush, error, reset.
// Expectations follow ICACHE_REFILL_CWF_EN when defined.
module tb_icache_refill_assembler;
`ifdef ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [55:0]  req_paddr_i;
    logic         req_nc_i;
    logic [1:0]   req_tid_i;
    logic         rtrn_valid_o;
    logic [127:0] rtrn_data_o;
    logic [1:0]   rtrn_tid_o;
    logic         rtrn_err_o;
    logic         busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    icache_refill_assembler_if #(.BeatWidth(64), .PlenWidth(56), .IdWidth(4)) axi ();

    icache_refill_assembler #(
        .LineWidth(128), .BeatWidth(64), .PlenWidth(56),
        .IdWidth(4), .TidWidth(2), .AxiId(0)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_paddr_i  (req_paddr_i),
        .req_nc_i     (req_nc_i),
        .req_tid_i    (req_tid_i),
        .axi          (axi),
        .rtrn_valid_o (rtrn_valid_o),
        .rtrn_data_o  (rtrn_data_o),
        .rtrn_tid_o   (rtrn_tid_o),
        .rtrn_err_o   (rtrn_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Issue a request, check the AR beat, then complete the handshake.
    task automatic start_req(input logic [55:0] pa, input logic nc,
                             input logic [1:0] tid, input logic [55:0] exp_addr,
                             input logic [7:0] exp_len, input logic [1:0] exp_burst);
        chk("req_ready_idle", req_ready_o, 1);
        req_valid_i = 1; req_paddr_i = pa; req_nc_i = nc; req_tid_i = tid;
        tick();
        req_valid_i = 0;
        chk("ar_valid", axi.ar_valid_o, 1);
        chk("ar_addr", axi.ar_addr_o, exp_addr);
        chk("ar_len", axi.ar_len_o, exp_len);
        chk("ar_burst", axi.ar_burst_o, exp_burst);
        chk("ar_size", axi.ar_size_o, 3);
        chk("ar_id", axi.ar_id_o, 0);
        axi.ar_ready_i = 1;
        tick();
        axi.ar_ready_i = 0;
        chk("r_ready", axi.r_ready_o, 1);
    endtask

    task automatic beat(input logic [63:0] d, input logic last,
                        input logic [1:0] resp);
        axi.r_valid_i = 1; axi.r_data_i = d; axi.r_last_i = last;
        axi.r_resp_i = resp;
        tick();
        axi.r_valid_i = 0; axi.r_last_i = 0; axi.r_resp_i = 0;
    endtask

    task automatic expect_rtrn(input logic [127:0] data, input logic [1:0] tid,
                               input logic err);
        chk("rtrn_valid", rtrn_valid_o, 1);
        chk("rtrn_data", rtrn_data_o, data);
        chk("rtrn_tid", rtrn_tid_o, tid);
        chk("rtrn_err", rtrn_err_o, err);
        chk("req_ready_rtrn", req_ready_o, 1);
        tick();
        chk("rtrn_pulse_end", rtrn_valid_o, 0);
    endtask

    task automatic reset_checks();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_ar_valid", axi.ar_valid_o, 0);
        chk("rst_ar_addr", axi.ar_addr_o, 0);
        chk("rst_r_ready", axi.r_ready_o, 0);
        chk("rst_rtrn_valid", rtrn_valid_o, 0);
        chk("rst_rtrn_data", rtrn_data_o, 0);
    endtask

    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] WRAP = 2'b10;

    initial begin
        logic [63:0] a, b, c, d, e, f, g, h, i, j, k, l;
        logic [55:0] stable_addr;
        a = 64'hAAAA_0000_1111_2222; b = 64'hBBBB_3333_4444_5555;
        c = 64'hCCCC_6666_7777_8888; d = 64'hDDDD_0001_0002_0003;
        e = 64'hEEEE_0004_0005_0006; f = 64'hF0F0_1234_5678_9ABC;
        g = 64'h0F0F_CBA9_8765_4321; h = 64'h1111_2222_3333_4444;
        i = 64'h5555_6666_7777_8888; j = 64'h9999_AAAA_BBBB_CCCC;
        k = 64'hDEAD_BEEF_0000_0001; l = 64'hCAFE_F00D_0000_0002;

        rst_i = 1; flush_i = 0; req_valid_i = 0; req_paddr_i = 0;
        req_nc_i = 0; req_tid_i = 0;
        axi.ar_ready_i = 0; axi.r_valid_i = 0; axi.r_data_i = 0;
        axi.r_last_i = 0; axi.r_resp_i = 0;
        tick(); tick();
        rst_i = 0;
        reset_checks();

        // Cached fill; CWF build gets the critical word (B) first.
        start_req(56'h8000_0018, 0, 2'd1,
                  CWF ? 56'h8000_0018 : 56'h8000_0010, 8'd1,
                  CWF ? WRAP : INCR);
        beat(CWF ? b : a, 0, 2'b00);
        chk("no_early_rtrn", rtrn_valid_o, 0);
        beat(CWF ? a : b, 1, 2'b00);
        expect_rtrn({b, a}, 2'd1, 0);

        // Flush in IDLE is ignored.
        flush_i = 1; tick(); flush_i = 0;
        chk("idle_flush_busy", busy_o, 0);

        // Non-cacheable single word.
        start_req(56'h1000_000C, 1, 2'd2, 56'h1000_0008, 8'd0, INCR);
        beat(c, 1, 2'b00);
        expect_rtrn({64'h0, c}, 2'd2, 0);

        // AR stall with a flush pulse: AR held, burst drained, no return.
        req_valid_i = 1; req_paddr_i = 56'h2000_0048; req_nc_i = 0;
        req_tid_i = 2'd3;
        tick();
        req_valid_i = 0;
        stable_addr = CWF ? 56'h2000_0048 : 56'h2000_0040;
        for (int n = 0; n < 5; n++) begin
            flush_i = (n == 1);
            chk("stall_ar_valid", axi.ar_valid_o, 1);
            chk("stall_ar_addr", axi.ar_addr_o, stable_addr);
            tick();
        end
        flush_i = 0;
        chk("stall_ar_valid_end", axi.ar_valid_o, 1);
        axi.ar_ready_i = 1; tick(); axi.ar_ready_i = 0;
        chk("drain_r_ready", axi.r_ready_o, 1);
        beat(d, 0, 2'b00);
        chk("drain_busy", busy_o, 1);
        chk("drain_rtrn0", rtrn_valid_o, 0);
        beat(e, 1, 2'b00);
        chk("drain_busy_low", busy_o, 0);
        chk("drain_rtrn1", rtrn_valid_o, 0);
        tick();
        chk("drain_rtrn2", rtrn_valid_o, 0);

        // Bus error on second beat is reported, then cleared for next fill.
        start_req(56'h3000_0000, 0, 2'd0, 56'h3000_0000, 8'd1,
                  CWF ? WRAP : INCR);
        beat(d, 0, 2'b00);
        beat(e, 1, 2'b10);
        expect_rtrn({e, d}, 2'd0, 1);
        start_req(56'h3000_0020, 0, 2'd1, 56'h3000_0020, 8'd1,
                  CWF ? WRAP : INCR);
        beat(f, 0, 2'b00);
        beat(g, 1, 2'b00);
        expect_rtrn({g, f}, 2'd1, 0);

        // Reset in the middle of a burst, then a clean fill.
        start_req(56'h4000_0000, 0, 2'd2, 56'h4000_0000, 8'd1,
                  CWF ? WRAP : INCR);
        beat(h, 0, 2'b00);
        rst_i = 1; tick(); rst_i = 0;
        reset_checks();
        start_req(56'h4000_0000, 0, 2'd3, 56'h4000_0000, 8'd1,
                  CWF ? WRAP : INCR);
        beat(i, 0, 2'b00);
        beat(j, 1, 2'b00);
        expect_rtrn({j, i}, 2'd3, 0);

        // Flush coinciding with the last beat: no return, back to idle.
        start_req(56'h5000_0000, 0, 2'd1, 56'h5000_0000, 8'd1,
                  CWF ? WRAP : INCR);
        beat(k, 0, 2'b00);
        flush_i = 1;
        beat(l, 1, 2'b00);
        flush_i = 0;
        chk("flush_last_rtrn", rtrn_valid_o, 0);
        chk("flush_last_busy", busy_o, 0);
        chk("flush_last_ready", req_ready_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
